// File: rtl/btb_if.sv
// btb_if: lookup/update/flush bundle between a BTB and its fetch/resolve logic
interface btb_if #(
    parameter int WAYS = 4
);
    localparam int WW = $clog2(WAYS);
    logic          lookup_valid;
    logic [15:0]   lookup_pc;
    logic          lookup_hit;
    logic [15:0]   lookup_target;
    logic [WW-1:0] lookup_way;
    logic          upd_valid;
    logic [15:0]   upd_pc;
    logic [15:0]   upd_target;
    logic          flush;
    modport master (
        output lookup_valid, lookup_pc, upd_valid, upd_pc, upd_target, flush,
        input  lookup_hit, lookup_target, lookup_way
    );
    modport slave (
        input  lookup_valid, lookup_pc, upd_valid, upd_pc, upd_target, flush,
        output lookup_hit, lookup_target, lookup_way
    );
endinterface

// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer, 1-cycle registered lookup,
// per-set round-robin replacement once a set is full
module btb_assoc #(
    parameter int WAYS = 4,
    parameter int SETS = 8
) (
    input logic  clk,
    input logic  rst,
    btb_if.slave bus
);
    localparam int IW = $clog2(SETS);
    localparam int WW = $clog2(WAYS);
    localparam int TW = 16 - IW - 1;

    logic [WAYS-1:0] r_valid [SETS];
    logic [WW-1:0]   r_ptr   [SETS];
    logic [TW-1:0]   r_tag   [SETS][WAYS];
    logic [15:0]     r_tgt   [SETS][WAYS];
    logic            r_hit;
    logic [15:0]     r_target;
    logic [WW-1:0]   r_way;

    logic [IW-1:0] w_lidx, w_uidx;
    logic [TW-1:0] w_ltag, w_utag;
    logic          w_lhit, w_uhit, w_ufree, w_lgo, w_wr;
    logic [WW-1:0] w_lway, w_uway, w_fway, w_wway;
    logic          w_unused;

    assign w_lidx   = bus.lookup_pc[IW:1];
    assign w_ltag   = bus.lookup_pc[15:IW+1];
    assign w_uidx   = bus.upd_pc[IW:1];
    assign w_utag   = bus.upd_pc[15:IW+1];
    assign w_unused = ^{bus.lookup_pc[0], bus.upd_pc[0]};

    // descending scan so the lowest matching/free way is the one left standing
    always_comb begin
        w_lhit  = 1'b0;
        w_lway  = '0;
        w_uhit  = 1'b0;
        w_uway  = '0;
        w_ufree = 1'b0;
        w_fway  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_lidx][w] && r_tag[w_lidx][w] == w_ltag) begin
                w_lhit = 1'b1;
                w_lway = WW'(w);
            end
            if (r_valid[w_uidx][w] && r_tag[w_uidx][w] == w_utag) begin
                w_uhit = 1'b1;
                w_uway = WW'(w);
            end
            if (!r_valid[w_uidx][w]) begin
                w_ufree = 1'b1;
                w_fway  = WW'(w);
            end
        end
    end

    assign w_wway = w_uhit ? w_uway : w_ufree ? w_fway : r_ptr[w_uidx];
    assign w_lgo  = bus.lookup_valid && w_lhit;
    assign w_wr   = bus.upd_valid && !bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_ptr[s]   <= '0;
            end
            r_hit    <= 1'b0;
            r_target <= '0;
            r_way    <= '0;
        end else if (bus.flush) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_ptr[s]   <= '0;
            end
            r_hit    <= 1'b0;
            r_target <= '0;
            r_way    <= '0;
        end else begin
            r_hit    <= w_lgo;
            r_target <= w_lgo ? r_tgt[w_lidx][w_lway] : '0;
            r_way    <= w_lgo ? w_lway : '0;
            if (bus.upd_valid) begin
                r_valid[w_uidx][w_wway] <= 1'b1;
                if (!w_uhit && !w_ufree) r_ptr[w_uidx] <= r_ptr[w_uidx] + 1'b1;
            end
        end
    end

    // tag/target storage needs no reset: valid bits gate every hit
    always_ff @(posedge clk) begin
        if (w_wr && !rst) begin
            r_tag[w_uidx][w_wway] <= w_utag;
            r_tgt[w_uidx][w_wway] <= bus.upd_target;
        end
    end

    assign bus.lookup_hit    = r_hit;
    assign bus.lookup_target = r_target;
    assign bus.lookup_way    = r_way;
endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: directed + randomized check of btb_assoc against a table model
module tb_btb_assoc;
    localparam int WAYS = 4;
    localparam int SETS = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    btb_if #(.WAYS(WAYS)) bus();
    btb_assoc #(.WAYS(WAYS), .SETS(SETS)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit mv [SETS][WAYS];
    int mt [SETS][WAYS];
    int mg [SETS][WAYS];
    int mp [SETS];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_set(int pc);
        return (pc / 2) % SETS;
    endfunction

    function automatic int m_tag(int pc);
        return (pc % 65536) / (2 * SETS);
    endfunction

    task automatic m_clear();
        for (int s = 0; s < SETS; s++) begin
            mp[s] = 0;
            for (int w = 0; w < WAYS; w++) mv[s][w] = 0;
        end
    endtask

    function automatic int m_find(int pc);
        for (int w = 0; w < WAYS; w++)
            if (mv[m_set(pc)][w] && mt[m_set(pc)][w] == m_tag(pc)) return w;
        return -1;
    endfunction

    task automatic m_update(input int pc, input int tg);
        int s = m_set(pc);
        int w = m_find(pc);
        if (w < 0)
            for (int i = WAYS - 1; i >= 0; i--) if (!mv[s][i]) w = i;
        if (w < 0) begin
            w = mp[s];
            mp[s] = (mp[s] + 1) % WAYS;
        end
        mv[s][w] = 1;
        mt[s][w] = m_tag(pc);
        mg[s][w] = tg;
    endtask

    task automatic step(input string tag, input bit lv, input int lpc, input bit uv,
                        input int upc, input int utg, input bit fl);
        int w;
        int e_tgt;
        bus.lookup_valid = lv;
        bus.lookup_pc    = 16'(lpc);
        bus.upd_valid    = uv;
        bus.upd_pc       = 16'(upc);
        bus.upd_target   = 16'(utg);
        bus.flush        = fl;
        @(posedge clk);
        w = (lv && !fl) ? m_find(lpc) : -1;
        e_tgt = (w >= 0) ? mg[m_set(lpc)][w] : 0;
        if (fl) m_clear();
        else if (uv) m_update(upc, utg);
        #1;
        chk({tag, ".hit"}, 32'(bus.lookup_hit), (w >= 0) ? 1 : 0);
        chk({tag, ".tgt"}, 32'(bus.lookup_target), e_tgt);
        chk({tag, ".way"}, 32'(bus.lookup_way), (w >= 0) ? w : 0);
    endtask

    initial begin
        m_clear();
        bus.lookup_valid = 0; bus.lookup_pc = 0; bus.upd_valid = 0;
        bus.upd_pc = 0; bus.upd_target = 0; bus.flush = 0;
        #2 rst = 1'b1;
        #1;
        chk("rst.hit", 32'(bus.lookup_hit), 0);
        chk("rst.tgt", 32'(bus.lookup_target), 0);
        chk("rst.way", 32'(bus.lookup_way), 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;

        step("r34", 1, 'h3002, 0, 0, 0, 0);
        step("r35u", 0, 0, 1, 'h3002, 'h4000, 0);
        step("r35a", 1, 'h3002, 0, 0, 0, 0);
        chk("r35.tgt_const", 32'(bus.lookup_target), 'h4000);
        step("r35b", 1, 'h5002, 0, 0, 0, 0);
        chk("r35.miss_const", 32'(bus.lookup_hit), 0);

        step("fl36", 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) step("r36f", 0, 0, 1, i * 'h1000 + 2, 'hA000 + i, 0);
        step("r36u5", 0, 0, 1, 'h5002, 'hA005, 0);
        step("r36l5", 1, 'h5002, 0, 0, 0, 0);
        chk("r36.way5", 32'(bus.lookup_way), 0);
        step("r36u6", 0, 0, 1, 'h6002, 'hA006, 0);
        step("r36l6", 1, 'h6002, 0, 0, 0, 0);
        chk("r36.way6", 32'(bus.lookup_way), 1);
        step("r36l1", 1, 'h1002, 0, 0, 0, 0);
        chk("r36.miss1", 32'(bus.lookup_hit), 0);
        step("r36l3", 1, 'h3003, 0, 0, 0, 0);

        step("fl37", 0, 0, 0, 0, 0, 1);
        step("r37u", 0, 0, 1, 'h3002, 'h4000, 0);
        step("r37rw", 1, 'h3002, 1, 'h3002, 'h4800, 0);
        chk("r37.old", 32'(bus.lookup_target), 'h4000);
        step("r37nx", 1, 'h3002, 0, 0, 0, 0);
        chk("r37.new", 32'(bus.lookup_target), 'h4800);
        for (int i = 1; i <= 3; i++) step("r37f", 0, 0, 1, i * 'h1000 + 'h8002, 'hB000 + i, 0);
        step("r37r", 0, 0, 1, 'hC002, 'hBBBB, 0);
        step("r37lr", 1, 'hC002, 0, 0, 0, 0);
        chk("r37.ptr", 32'(bus.lookup_way), 0);

        step("r38p", 0, 0, 1, 'h3002, 'h1111, 0);
        step("r38f", 1, 'h3002, 1, 'h7002, 'h2222, 1);
        step("r38a", 1, 'h7002, 0, 0, 0, 0);
        chk("r38.miss7", 32'(bus.lookup_hit), 0);
        step("r38b", 1, 'h3002, 0, 0, 0, 0);

        step("r39u", 0, 0, 1, 'h3002, 'h1234, 0);
        step("r39l", 1, 'h3002, 0, 0, 0, 0);
        chk("r39.pre", 32'(bus.lookup_hit), 1);
        #3 rst = 1'b1;
        #1 chk("r39.async", 32'(bus.lookup_hit), 0);
        m_clear();
        bus.upd_valid = 1; bus.upd_pc = 16'h7002; bus.upd_target = 16'h5555;
        @(posedge clk);
        #2 rst = 1'b0;
        step("r39a", 1, 'h7002, 0, 0, 0, 0);
        step("r39b", 1, 'h3002, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++)
            step("rnd", $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 5) << 4) | ($urandom_range(0, 7) << 1) | $urandom_range(0, 1),
                 $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 5) << 4) | ($urandom_range(0, 7) << 1) | $urandom_range(0, 1),
                 $urandom_range(0, 65535), $urandom_range(0, 39) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 Parameter WAYS, default 4, number of ways per set; power of two, 2..8.
REQ-002 Parameter SETS, default 8, number of sets; power of two, 2..64.
REQ-003 Derived: IW = log2(SETS), WW = log2(WAYS), TW = 16-IW-1.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 lookup_valid  input  1  lookup request this cycle.
REQ-007 lookup_pc  input  16  fetch PC; bit 0 ignored.
REQ-008 lookup_hit  output  1  registered; the previous-cycle lookup hit.
REQ-009 lookup_target  output  16  registered; predicted target when lookup_hit=1, else 16'h0000.
REQ-010 lookup_way  output  WW  registered; way that supplied lookup_target, else 0.
REQ-011 upd_valid  input  1  install or refresh request (resolved taken branch).
REQ-012 upd_pc  input  16  branch PC to install.
REQ-013 upd_target  input  16  resolved target.
REQ-014 flush  input  1  synchronous invalidate-all.

Function
REQ-015 Index = pc[IW:1]; tag = pc[15:IW+1]; storage per entry: valid, TW-bit tag, 16-bit target.
REQ-016 Per set, one WW-bit round-robin replacement pointer.
REQ-017 Lookup latency 1 cycle: lookup_valid/lookup_pc sampled at edge N; result visible after edge N.
REQ-018 Hit = valid AND tag match in any way of the indexed set.
REQ-019 Multiple matching ways: the lowest way index wins (priority encode, way 0 highest).
REQ-020 lookup_valid=0 at edge: outputs go to hit=0, target=0, way=0 at that edge.
REQ-021 Update, upd_pc already present (hit, lowest way): overwrite target only; pointer unchanged.
REQ-022 Update miss, with an invalid way in set: write the lowest-index invalid way; pointer unchanged.
REQ-023 Update miss, set full: write way at pointer; pointer advances by 1 mod WAYS.
REQ-024 Write sets valid=1 and stores tag and target; effective from the next edge.
REQ-025 Lookup and update in the same cycle to the same entry: lookup returns pre-update contents (read-before-write).
REQ-026 flush=1: all valid bits and all pointers cleared at that edge; registered outputs cleared to 0.
REQ-027 flush and upd_valid together: flush wins; no entry written.
REQ-028 flush and lookup_valid together: lookup reports miss.
REQ-029 No backpressure: one lookup and one update accepted every cycle.

Reset
REQ-030 rst=1: immediately (no clock needed) all valid bits=0, all pointers=0, lookup_hit=0, lookup_target=16'h0000, lookup_way=0.
REQ-031 Tag/target arrays need not be reset; a lookup must never hit an entry with valid=0.
REQ-032 rst asserted mid-operation: in-flight update discarded; first lookup after release misses.
REQ-033 State update resumes at the first rising edge after rst deasserts.

Verification (WAYS=4, SETS=8: index=pc[3:1], tag=pc[15:4])
REQ-034 After reset, lookup 16'h3002 -> next cycle hit=0, target=0, way=0.
REQ-035 Update pc=16'h3002 tgt=16'h4000, then lookup 16'h3002 -> hit=1, target=16'h4000, way=0; lookup 16'h5002 (same set, other tag) -> hit=0.
REQ-036 Fill set 1 with tags for pcs 16'h1002,2002,3002,4002 (ways 0..3), then update 16'h5002 -> replaces way 0; pointer=1; then 16'h6002 replaces way 1; lookup 16'h1002 misses.
REQ-037 Update 16'h3002 tgt=16'h4000, then same-cycle lookup 16'h3002 with update tgt=16'h4800 -> returns 16'h4000; next lookup returns 16'h4800 in same way, pointer unchanged.
REQ-038 Populated entries, assert flush together with upd_valid 16'h7002 -> all subsequent lookups, including 16'h7002, miss.
REQ-039 Assert rst asynchronously between edges while lookup_hit=1 -> lookup_hit falls to 0 before the next edge; no entry hits afterward.
